// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit for the OTTER RV32I core.
// Runs one access at a time over a req/ack data-memory bus. It returns
// lane-extracted, sign/zero-extended load data and stalls the pipeline
// while an access is outstanding.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned accesses complete with out_err=1 and no bus cycle
//   undefined : misaligned low address bits are masked to size alignment
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_we,
    input  logic        in_re,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic [1:0]  acc_size;
    logic        acc_mem;
    logic [31:0] acc_addr;
    logic        acc_go_req;
    logic        acc_err;

    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [3:0]  be_mask;

`ifdef LSU_MISALIGN_TRAP_EN
    logic        err_q;
    logic        acc_mis;
`endif

    // Decode the access presented in IDLE: normalised size and routing.
    always_comb begin
        acc_size = (in_size == 2'b11) ? 2'b10 : in_size;
        acc_mem  = in_we | in_re;
`ifdef LSU_MISALIGN_TRAP_EN
        acc_mis    = ((acc_size == 2'b01) && in_addr[0]) ||
                     ((acc_size == 2'b10) && (in_addr[1:0] != 2'b00));
        acc_addr   = in_addr;
        acc_err    = acc_mem & acc_mis;
        acc_go_req = acc_mem & ~acc_mis;
`else
        acc_addr = in_addr;
        case (acc_size)
            2'b01:   acc_addr[0]   = 1'b0;
            2'b10:   acc_addr[1:0] = 2'b00;
            default: acc_addr      = in_addr;
        endcase
        acc_err    = 1'b0;
        acc_go_req = acc_mem;
`endif
    end

    // Extract and extend the addressed lane of the returned read word.
    always_comb begin
        shifted = bus_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = uns_q ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = bus_rdata;
        endcase
    end

    // Byte-enable mask and lane-replicated store data from latched access.
    always_comb begin
        case (size_q)
            2'b00: begin
                be_mask   = 4'b0001 << addr_q[1:0];
                bus_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_mask   = 4'b0011 << addr_q[1:0];
                bus_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                be_mask   = 4'b1111;
                bus_wdata = wdata_q;
            end
        endcase
    end

    // Control FSM and access latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        addr_q  <= acc_addr;
                        wdata_q <= in_wdata;
                        we_q    <= in_we;
                        size_q  <= acc_size;
                        uns_q   <= in_unsigned;
                        rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        err_q   <= acc_err;
`endif
                        state   <= acc_go_req ? ST_REQ : ST_RESP;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        rdata_q <= we_q ? '0 : load_data;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state; rst masks a pending RESP pulse.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        busy      = ~in_ready;
        bus_req   = (state == ST_REQ);
        bus_we    = bus_req & we_q;
        bus_be    = bus_req ? be_mask : 4'b0000;
        bus_addr  = {addr_q[31:2], 2'b00};
        out_valid = (state == ST_RESP) & ~rst;
        out_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        out_err   = err_q;
`else
        out_err   = acc_err & 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu (default build: misalignment masked).
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_we;
    logic        in_re;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        busy;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int unsigned vecs = 0;
    int unsigned miss = 0;

    mem_stage_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_we      (in_we),
        .in_re      (in_re),
        .in_size    (in_size),
        .in_unsigned(in_unsigned),
        .out_valid  (out_valid),
        .out_rdata  (out_rdata),
        .out_err    (out_err),
        .busy       (busy),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access. Called at a negedge with the DUT idle; returns at
    // the negedge where it is idle again. waitc = ack wait cycles.
    task automatic access(input logic [31:0] a, input logic [31:0] wd,
                          input logic we, input logic re, input logic [1:0] sz,
                          input logic uns, input int unsigned waitc,
                          input logic [31:0] rd);
        int unsigned sbytes;
        int unsigned lane;
        logic [31:0] ea;
        logic [31:0] ebe;
        logic [31:0] ewd;
        logic [31:0] erd;
        logic [31:0] v;
        logic [31:0] wd_b;
        logic [31:0] wd_h;

        // Reference: sizes in bytes, alignment by modulo arithmetic.
        sbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ea     = a - (a % sbytes);
        lane   = ea % 4;
        ebe    = (sbytes == 4) ? 32'd15 : (((1 << sbytes) - 1) << lane);
        wd_b   = wd % 256;
        wd_h   = wd % 65536;
        ewd    = (sbytes == 1) ? wd_b * 32'h01010101 :
                 (sbytes == 2) ? wd_h * 32'h00010001 : wd;
        v      = rd >> (8 * lane);
        if (sbytes == 1) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sbytes == 2) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end
        erd = (re && !we) ? v : 32'd0;

        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        in_valid    = 1'b1;
        in_addr     = a;
        in_wdata    = wd;
        in_we       = we;
        in_re       = re;
        in_size     = sz;
        in_unsigned = uns;
        bus_rdata   = rd;
        bus_ack     = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid    = 1'b0;
        in_addr     = $urandom;
        in_wdata    = $urandom;
        in_size     = 2'($urandom);
        in_unsigned = 1'($urandom);

        if (we || re) begin
            for (int unsigned i = 0; i <= waitc; i++) begin
                chk("req_high", bus_req, 1);
                chk("req_addr", bus_addr, ea & 32'hFFFFFFFC);
                chk("req_be", 32'(bus_be), ebe);
                chk("req_we", bus_we, 32'(we));
                chk("req_busy", busy, 1);
                chk("req_no_valid", out_valid, 0);
                if (we) chk("req_wdata", bus_wdata, ewd);
                bus_ack = (i == waitc);
                @(negedge clk);
            end
            bus_ack = 1'b0;
        end else begin
            bus_ack = 1'($urandom_range(0, 1));
        end
        chk("resp_valid", out_valid, 1);
        chk("resp_no_req", bus_req, 0);
        chk("resp_rdata", out_rdata, erd);
        chk("resp_err", out_err, 0);
        chk("resp_not_ready", in_ready, 0);
        @(negedge clk);
        bus_ack = 1'b0;
        chk("post_valid_low", out_valid, 0);
        chk("post_ready", in_ready, 1);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_addr     = '0;
        in_wdata    = '0;
        in_we       = 1'b0;
        in_re       = 1'b0;
        in_size     = 2'b00;
        in_unsigned = 1'b0;
        bus_ack     = 1'b0;
        bus_rdata   = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_be", 32'(bus_be), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rdata", out_rdata, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        access(32'h100, 32'hDEADBEEF, 1, 0, 2'b10, 0, 2, 32'h0);           // SW, 2 waits
        access(32'h103, 32'h000000A5, 1, 0, 2'b00, 0, 0, 32'h0);           // SB lane 3
        access(32'h102, 32'h0, 0, 1, 2'b00, 0, 0, 32'h12F03456);           // LB
        access(32'h102, 32'h0, 0, 1, 2'b00, 1, 1, 32'h12F03456);           // LBU
        access(32'h102, 32'h0, 0, 1, 2'b01, 0, 0, 32'h80011234);           // LH
        access(32'h101, 32'h0, 0, 1, 2'b10, 0, 0, 32'hCAFEF00D);           // LW misaligned
        access(32'h40, 32'h0, 0, 1, 2'b11, 1, 0, 32'h89ABCDEF);            // size 11 as word
        access(32'h44, 32'h1234ABCD, 1, 1, 2'b01, 0, 0, 32'hFFFFFFFF);     // we+re -> store
        access(32'h48, 32'h55, 0, 0, 2'b10, 0, 0, 32'hFFFFFFFF);           // no-op

        // Reset while a request is outstanding.
        in_valid = 1'b1; in_addr = 32'h300; in_we = 1'b0; in_re = 1'b1;
        in_size = 2'b10; in_unsigned = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midreq_req", bus_req, 1);
        @(negedge clk);
        chk("midreq_req_hold", bus_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreq_rst_req", bus_req, 0);
        chk("midreq_rst_valid", out_valid, 0);
        chk("midreq_rst_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midreq_after_valid", out_valid, 0);
        chk("midreq_after_req", bus_req, 0);
        access(32'h200, 32'h0, 0, 1, 2'b10, 0, 1, 32'h11223344);

        // Reset during the completion cycle suppresses the pulse.
        in_valid = 1'b1; in_we = 1'b0; in_re = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("resp_rst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("resp_rst_ready", in_ready, 1);
        chk("resp_rst_valid2", out_valid, 0);

        // Randomized accesses.
        for (int n = 0; n < 60; n++) begin
            access($urandom, $urandom, 1'($urandom), 1'($urandom), 2'($urandom),
                   1'($urandom), $urandom_range(0, 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
